// File: rtl/td4_pkg.sv
// td4_pkg: shared constants for the TD4 4-bit CPU.
// Data width, opcode encodings and a small decode helper.
package td4_pkg;

  localparam int DW = 4;
  localparam int AW = 4;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  function automatic logic is_add_b(input logic [3:0] op);
    return op == OP_ADD_B;
  endfunction

endpackage

// File: rtl/td4_core_if.sv
// td4_core_if: ROM fetch bus plus I/O port and carry of the TD4 core.
// master = core side (drives rom_addr/port_out/carry); slave = ROM/board side.
interface td4_core_if;
  import td4_pkg::*;

  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [DW-1:0] in_port;
  logic [DW-1:0] port_out;
  logic          carry;

  modport master (
    output rom_addr, port_out, carry,
    input  rom_data, in_port
  );

  modport slave (
    input  rom_addr, port_out, carry,
    output rom_data, in_port
  );

endinterface

// File: rtl/td4_core_step_gen.sv
// step_gen: instruction step tick from a clock divider or a push-button.
// Ports: clk, rst_n, manual_i, step_btn_i (async), tick_o (1-clk pulse).
module step_gen #(
  parameter int unsigned STEP_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic manual_i,
  input  logic step_btn_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(STEP_DIV);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          div_tick;
  logic          sync1_q, sync2_q, edge_q;
  logic [2:0]    vld_q;
  logic          btn_tick;

  assign div_tick = (cnt_q == LAST);
  assign cnt_d    = div_tick ? '0 : cnt_q + CW'(1);

  // vld_q marks when edge_q holds a real button sample, so a
  // button already held at reset release is never seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      vld_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sync1_q <= step_btn_i;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      vld_q   <= {vld_q[1:0], 1'b1};
    end
  end

  assign btn_tick = vld_q[2] & sync2_q & ~edge_q;
  assign tick_o   = manual_i ? btn_tick : div_tick;

endmodule

// File: rtl/td4_core.sv
// td4_core: TD4 4-bit CPU - registers A/B/PC/C/OUT, decode and ALU.
// Ports: clk, rst_n, manual, step_btn, bus (ROM fetch, in/out port, carry).
module td4_core
  import td4_pkg::*;
#(
  parameter int unsigned STEP_DIV = 50_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          manual,
  input  logic          step_btn,
  td4_core_if.master    bus
);

  logic tick;

  step_gen #(.STEP_DIV(STEP_DIV)) u_step (
    .clk        (clk),
    .rst_n      (rst_n),
    .manual_i   (manual),
    .step_btn_i (step_btn),
    .tick_o     (tick)
  );

  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] out_q, out_d;
  logic          c_q, c_d;

  logic [3:0]    op;
  logic [DW-1:0] im;
  logic [DW-1:0] add_src;
  logic [DW:0]   sum;

  assign op = bus.rom_data[7:4];
  assign im = bus.rom_data[3:0];

  // One shared adder; B is the operand only for the ADD B opcode.
  assign add_src = is_add_b(op) ? b_q : a_q;
  assign sum     = {1'b0, add_src} + {1'b0, im};

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    pc_d  = pc_q;
    out_d = out_q;
    c_d   = c_q;
    if (tick) begin
      pc_d = pc_q + AW'(1);
      c_d  = 1'b0;
      unique case (op)
        OP_ADD_A: begin
          a_d = sum[DW-1:0];
          c_d = sum[DW];
        end
        OP_MOV_AB: a_d = b_q;
        OP_IN_A:   a_d = bus.in_port;
        OP_MOV_A:  a_d = im;
        OP_MOV_BA: b_d = a_q;
        OP_ADD_B: begin
          b_d = sum[DW-1:0];
          c_d = sum[DW];
        end
        OP_IN_B:   b_d = bus.in_port;
        OP_MOV_B:  b_d = im;
        OP_OUT_B:  out_d = b_q;
        OP_OUT_IM: out_d = im;
        OP_JNC: begin
          if (!c_q) pc_d = im;
        end
        OP_JMP:    pc_d = im;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      pc_q  <= '0;
      out_q <= '0;
      c_q   <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      pc_q  <= pc_d;
      out_q <= out_d;
      c_q   <= c_d;
    end
  end

  assign bus.rom_addr = pc_q;
  assign bus.port_out = out_q;
  assign bus.carry    = c_q;

endmodule

// File: tb/tb_td4_core.sv
// tb_td4_core: TD4 core bench with an instruction-level model and
// directed plus random programs, STEP_DIV = 4.
module tb_td4_core;

  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic manual = 1'b0;
  logic step_btn = 1'b0;
  logic [7:0] rom [16];

  td4_core_if bus ();

  assign bus.rom_data = rom[bus.rom_addr];

  td4_core #(.STEP_DIV(SD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .manual   (manual),
    .step_btn (step_btn),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction-level model: registers as plain ints, step timing
  // from the edge count since reset and the sampled button history.
  int m_a, m_b, m_pc, m_c, m_out, m_n;
  bit h1, h2, h3;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_pc = 0; m_c = 0; m_out = 0; m_n = 0;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      bit tk;
      int op, im, s, nc, npc;
      logic [7:0] ins;
      m_n++;
      if (manual) tk = (m_n >= 4) && h2 && !h3;
      else tk = (m_n % SD) == 0;
      h3 = h2; h2 = h1; h1 = step_btn;
      if (tk) begin
        ins = rom[m_pc];
        op = int'(ins[7:4]);
        im = int'(ins[3:0]);
        nc = 0;
        npc = (m_pc + 1) % 16;
        case (op)
          0: begin s = m_a + im; m_a = s % 16; nc = s / 16; end
          1: m_a = m_b;
          2: m_a = int'(bus.in_port);
          3: m_a = im;
          4: m_b = m_a;
          5: begin s = m_b + im; m_b = s % 16; nc = s / 16; end
          6: m_b = int'(bus.in_port);
          7: m_b = im;
          9: m_out = m_b;
          11: m_out = im;
          14: if (m_c == 0) npc = im;
          15: npc = im;
          default: ;
        endcase
        m_c = nc;
        m_pc = npc;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model rom_addr", int'(bus.rom_addr), m_pc);
      chk("model port_out", int'(bus.port_out), m_out);
      chk("model carry", int'(bus.carry), m_c);
    end
  end

  task automatic run(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic load_nops();
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
  endtask

  initial begin
    bus.in_port = 4'd0;
    load_nops();
    run(2);
    chk("reset rom_addr", int'(bus.rom_addr), 0);
    chk("reset port_out", int'(bus.port_out), 0);
    chk("reset carry", int'(bus.carry), 0);
    chk_en = 1'b1;

    // ADD carry, JNC not taken, then expose A through B and OUT
    load_nops();
    rom[0] = 8'h33; rom[1] = 8'h0E; rom[2] = 8'hE0;
    rom[3] = 8'h40; rom[4] = 8'h90;
    do_reset();
    run(8);
    chk("add carry", int'(bus.carry), 1);
    chk("add pc", int'(bus.rom_addr), 2);
    run(4);
    chk("jnc carry", int'(bus.carry), 0);
    chk("jnc pc", int'(bus.rom_addr), 3);
    run(8);
    chk("a wrapped", int'(bus.port_out), 1);

    // OUT Im holds through NOPs
    load_nops();
    rom[0] = 8'hB7;
    do_reset();
    run(4);
    chk("out im", int'(bus.port_out), 7);
    run(40);
    chk("out hold", int'(bus.port_out), 7);
    chk("nop carry", int'(bus.carry), 0);

    // PC wraps after sixteen NOPs
    load_nops();
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      run(4);
      chk("pc seq", int'(bus.rom_addr), k % 16);
    end

    // Manual: held button gives one step, divider ignored
    manual = 1'b1;
    step_btn = 1'b0;
    load_nops();
    do_reset();
    run(20);
    chk("manual idle", int'(bus.rom_addr), 0);
    step_btn = 1'b1;
    run(100);
    step_btn = 1'b0;
    run(10);
    chk("manual one", int'(bus.rom_addr), 1);

    // Button held through reset release does not step
    step_btn = 1'b1;
    do_reset();
    run(20);
    chk("held reset", int'(bus.rom_addr), 0);
    step_btn = 1'b0;
    run(5);
    step_btn = 1'b1;
    run(6);
    chk("press after", int'(bus.rom_addr), 1);
    step_btn = 1'b0;
    manual = 1'b0;

    // IN B then OUT B
    load_nops();
    rom[0] = 8'h60; rom[1] = 8'h90;
    bus.in_port = 4'b1010;
    do_reset();
    run(8);
    chk("in out", int'(bus.port_out), 10);

    // Asynchronous reset mid-step
    load_nops();
    rom[0] = 8'hB7; rom[1] = 8'h3F; rom[2] = 8'h01;
    do_reset();
    run(12);
    chk("pre rst out", int'(bus.port_out), 7);
    chk("pre rst c", int'(bus.carry), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async out", int'(bus.port_out), 0);
    chk("async c", int'(bus.carry), 0);
    chk("async pc", int'(bus.rom_addr), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run(3);
    chk("post rst wait", int'(bus.rom_addr), 0);
    run(1);
    chk("post rst tick", int'(bus.rom_addr), 1);
    chk("post rst out", int'(bus.port_out), 7);

    // Random programs, both modes
    for (int ph = 0; ph < 6; ph++) begin
      manual = ph[0];
      step_btn = 1'b0;
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      do_reset();
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        bus.in_port = 4'($urandom);
        if (manual && $urandom_range(0, 5) == 0) step_btn = ~step_btn;
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/td4_core.md
TD4_CORE -- requirements
Module: td4_core

Interface
REQ-001 Parameter STEP_DIV, default 50_000_000, clk cycles per auto-mode instruction step; legal range 2..2^26.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rom_addr  output  4  instruction address, equal to PC.
REQ-005 rom_data  input  8  instruction from combinational ROM, [7:4] opcode, [3:0] immediate Im.
REQ-006 in_port  input  4  input port, sampled at execute edge.
REQ-007 manual  input  1  1 = steps from step_btn only; 0 = steps from divider; treated as static between steps.
REQ-008 step_btn  input  1  asynchronous push-button, active-high.
REQ-009 port_out  output  4  registered output port, feeds the 7-segment bit-display decoder.
REQ-010 carry  output  1  registered carry flag C.

Function
REQ-011 Step tick: one-clk pulse; auto mode when divider count == STEP_DIV-1, count then wraps to 0; manual mode on rising edge of synchronized step_btn.
REQ-012 step_btn SHALL pass a 2-flop synchronizer, then a 1-flop edge detector; a held button yields exactly one tick.
REQ-013 In manual mode divider ticks SHALL be ignored; divider keeps counting.
REQ-014 Each tick executes one instruction at that edge; no state changes on non-tick cycles.
REQ-015 Opcodes: 0000 A=A+Im; 0001 A=B; 0010 A=in_port; 0011 A=Im; 0100 B=A; 0101 B=B+Im; 0110 B=in_port; 0111 B=Im; 1001 port_out=B; 1011 port_out=Im; 1110 JNC: PC=Im if C==0; 1111 JMP: PC=Im.
REQ-016 Undefined opcodes (1000,1010,1100,1101) SHALL be NOPs.
REQ-017 ADD: 4-bit sum, result mod 16; C = bit 4 of the 5-bit sum.
REQ-018 Every non-ADD instruction, including JNC/JMP/NOP, SHALL clear C at its tick.
REQ-019 JNC tests C as held before the tick.
REQ-020 When no jump is taken, PC = PC+1 mod 16, so 15 wraps to 0.
REQ-021 port_out SHALL hold its value until the next OUT instruction.
REQ-022 port_out SHALL change on the execute edge, zero additional latency.

Reset
REQ-023 rst_n low SHALL immediately force A, B, PC, C, port_out, divider count, and the synchronizer/edge flops to 0, including mid-step.
REQ-024 After release, the first auto tick SHALL occur on the STEP_DIV-th rising edge.
REQ-025 A button held through reset release SHALL NOT generate a tick.

Structure
REQ-026 Shared package td4_pkg SHALL hold the opcode constants and the 4-bit data width constant.
REQ-027 Sub-module step_gen SHALL contain the divider, synchronizer, edge detector and mode mux, and output the tick.
REQ-028 td4_core SHALL contain registers, decode and ALU.

Verification (STEP_DIV=4)
REQ-029 ROM 0:0x33, 1:0x0E -> after step 2: A=1, C=1; JNC (0xE0) at 2 not taken, PC=3, C=0.
REQ-030 ROM 0:0xB7 -> port_out=0111 on tick 1; stays 0111 through 10 NOP ticks.
REQ-031 Sixteen 0x80 NOPs from reset -> rom_addr 0..15 then 0; C stays 0.
REQ-032 manual=1, step_btn high 100 clk -> exactly one instruction; no divider-driven steps.
REQ-033 in_port=1010, ROM 0x60 then 0x90 -> port_out=1010 after tick 2.
REQ-034 rst_n low mid-run with port_out=0111 -> all outputs 0 asynchronously; the next auto tick follows STEP_DIV edges after release.
